// File: rtl/definition.sv
// definition: shared ifmap/weight width, row FSM state type and
// a saturation helper used by the pe_row_n convolution row.
package definition;

  localparam int width = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN
  } pe_row_state_t;

  // Clamp v into the signed range of an ow-bit word.
  function automatic logic signed [63:0] sat_clip(
    input logic signed [63:0] v,
    input int                 ow
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// pe_mac: one PE of the row. Holds a stationary weight and one
// window tap; ports: shift/clear controls, chain in/out, product.
module pe_mac
  import definition::*;
#(
  parameter int DW = width
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_sh,
  input  logic [DW-1:0]          w_in,
  output logic [DW-1:0]          w_out,
  input  logic                   x_sh,
  input  logic                   x_clr,
  input  logic [DW-1:0]          x_in,
  output logic [DW-1:0]          x_out,
  output logic signed [2*DW-1:0] prod
);

  logic [DW-1:0]   w_q, w_d;
  logic [DW-1:0]   x_q, x_d;
  logic [2*DW-1:0] w_ext;
  logic [2*DW-1:0] x_ext;

  always_comb begin
    w_d = w_q;
    if (w_sh) w_d = w_in;
    x_d = x_q;
    if (x_clr)     x_d = '0;
    else if (x_sh) x_d = x_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
      x_q <= '0;
    end else begin
      w_q <= w_d;
      x_q <= x_d;
    end
  end

  // Sign-extend both operands; the low 2*DW bits of the
  // product are then the exact signed result.
  assign w_ext = {{DW{w_q[DW-1]}}, w_q};
  assign x_ext = {{DW{x_q[DW-1]}}, x_q};
  assign prod  = $signed(w_ext * x_ext);
  assign w_out = w_q;
  assign x_out = x_q;

endmodule

// File: rtl/pe_row_n.sv
// pe_row_n: NUM_PE-tap signed 1-D convolution row with serial
// weight load, valid/ready streams and psum chaining.
// Ports: clk, rst (sync, high), en, weight stream (i_w_valid,
// i_w, o_w_ready), ifmap stream (i_valid, i_r, i_psum, i_last,
// o_ready), result stream (o_valid, o_psum, i_ready), o_done.
// Macro PE_ROW_SAT_EN: saturate the sum to OUT_W bits instead
// of wrapping.
module pe_row_n
  import definition::*;
#(
  parameter int NUM_PE = 4,
  parameter int DW     = width,
  parameter int OUT_W  = 2 * DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             i_w_valid,
  input  logic [DW-1:0]    i_w,
  output logic             o_w_ready,
  input  logic             i_valid,
  input  logic [DW-1:0]    i_r,
  input  logic [OUT_W-1:0] i_psum,
  input  logic             i_last,
  output logic             o_ready,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_psum,
  input  logic             i_ready,
  output logic             o_done
);

  localparam int ACC_W = 2 * DW + $clog2(NUM_PE) + 1;
  localparam int CW    = $clog2(NUM_PE + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_PE);

  pe_row_state_t    state_q, state_d;
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    fill_inc;
  logic             loaded_q, loaded_d;
  logic             v1_q, v1_d;
  logic [OUT_W-1:0] psum_q, psum_d;
  logic             o_valid_q, o_valid_d;
  logic [OUT_W-1:0] o_psum_q, o_psum_d;
  logic             o_done_q, o_done_d;

  logic w_sh, x_sh, x_clr;
  logic w_acc, x_acc;

  logic [DW-1:0]          w_chain [NUM_PE+1];
  logic [DW-1:0]          x_chain [NUM_PE+1];
  logic signed [2*DW-1:0] prod    [NUM_PE];
  logic signed [ACC_W-1:0] acc;
  logic [OUT_W-1:0]        red;

  // Weights enter at the top PE and shift down, so after
  // NUM_PE beats w[0] sits in PE 0. Samples enter at PE 0.
  assign w_chain[NUM_PE] = i_w;
  assign x_chain[0]      = i_r;

  for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
    pe_mac #(.DW(DW)) u_pe (
      .clk   (clk),
      .rst   (rst),
      .w_sh  (w_sh),
      .w_in  (w_chain[k+1]),
      .w_out (w_chain[k]),
      .x_sh  (x_sh),
      .x_clr (x_clr),
      .x_in  (x_chain[k]),
      .x_out (x_chain[k+1]),
      .prod  (prod[k])
    );
  end

  always_comb begin
    acc = {{(ACC_W-OUT_W){psum_q[OUT_W-1]}}, psum_q};
    for (int k = 0; k < NUM_PE; k++) begin
      acc = acc +
        {{(ACC_W-2*DW){prod[k][2*DW-1]}}, prod[k]};
    end
  end

`ifdef PE_ROW_SAT_EN
  logic signed [63:0] clip;
  always_comb begin
    clip = sat_clip(64'(acc), OUT_W);
    red  = clip[OUT_W-1:0];
  end
  logic unused_hi;
  assign unused_hi = ^{clip[63:OUT_W], w_chain[0],
                       x_chain[NUM_PE]};
`else
  assign red = acc[OUT_W-1:0];
  logic unused_hi;
  assign unused_hi = ^{acc[ACC_W-1:OUT_W], w_chain[0],
                       x_chain[NUM_PE]};
`endif

  assign fill_inc = (fill_q == FULL) ? FULL
                                     : fill_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    fill_d    = fill_q;
    loaded_d  = loaded_q;
    v1_d      = v1_q;
    psum_d    = psum_q;
    o_valid_d = o_valid_q;
    o_psum_d  = o_psum_q;
    o_done_d  = 1'b0;
    o_w_ready = 1'b0;
    o_ready   = 1'b0;
    w_sh      = 1'b0;
    x_sh      = 1'b0;
    x_clr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        o_w_ready = 1'b1;
        // a weight beat takes priority over a new row
        o_ready   = loaded_q & ~i_w_valid;
      end
      LOAD_W: o_w_ready = 1'b1;
      STREAM: o_ready = ~o_valid_q | i_ready;
      default: ;
    endcase

    w_acc = en & i_w_valid & o_w_ready;
    x_acc = en & i_valid & o_ready;

    // Stage 1 (window + sampled psum) moves into the
    // output register whenever that register is free.
    if (en & v1_q & (~o_valid_q | i_ready)) begin
      o_valid_d = 1'b1;
      o_psum_d  = red;
      v1_d      = 1'b0;
    end else if (en & o_valid_q & i_ready) begin
      o_valid_d = 1'b0;
    end

    if (x_acc) begin
      x_sh    = 1'b1;
      psum_d  = i_psum;
      fill_d  = fill_inc;
      v1_d    = (fill_inc == FULL);
      state_d = i_last ? DRAIN : STREAM;
    end

    unique case (state_q)
      IDLE: begin
        if (w_acc) begin
          w_sh     = 1'b1;
          wcnt_d   = CW'(1);
          loaded_d = 1'b0;
          state_d  = LOAD_W;
        end
      end
      LOAD_W: begin
        if (w_acc) begin
          w_sh = 1'b1;
          if (wcnt_q == FULL - 1'b1) begin
            wcnt_d   = '0;
            loaded_d = 1'b1;
            state_d  = STREAM;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (en & ~v1_q & (~o_valid_q | i_ready)) begin
          state_d  = IDLE;
          o_done_d = 1'b1;
          x_clr    = 1'b1;
          fill_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      fill_q    <= '0;
      loaded_q  <= 1'b0;
      v1_q      <= 1'b0;
      psum_q    <= '0;
      o_valid_q <= 1'b0;
      o_psum_q  <= '0;
      o_done_q  <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      fill_q    <= fill_d;
      loaded_q  <= loaded_d;
      v1_q      <= v1_d;
      psum_q    <= psum_d;
      o_valid_q <= o_valid_d;
      o_psum_q  <= o_psum_d;
      o_done_q  <= o_done_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_psum  = o_psum_q;
  assign o_done  = o_done_q;

endmodule

// File: tb/tb_pe_row_n.sv
// tb_pe_row_n: self-checking bench for pe_row_n (NUM_PE=4,
// DW=8, OUT_W=16) against a plain convolution model.
module tb_pe_row_n;

  logic        clk = 1'b0;
  logic        rst, en;
  logic        i_w_valid, o_w_ready;
  logic [7:0]  i_w, i_r;
  logic        i_valid, i_last, o_ready;
  logic [15:0] i_psum, o_psum;
  logic        o_valid, i_ready, o_done;

  pe_row_n #(.NUM_PE(4), .DW(8), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en),
    .i_w_valid(i_w_valid), .i_w(i_w), .o_w_ready(o_w_ready),
    .i_valid(i_valid), .i_r(i_r), .i_psum(i_psum),
    .i_last(i_last), .o_ready(o_ready),
    .o_valid(o_valid), .o_psum(o_psum),
    .i_ready(i_ready), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int w_m [4];
  int xs [64];
  int ps [64];
  int exp_q [$];
  int got_q [$];
  int got_cyc [$];
  int done_n, done_cyc, last_acc, stall_cnt, stall_bad;

  // y[t] = psum[t] + sum_k w[k]*x[t-k], reduced to 16 bits
  function automatic int model(int t);
    longint s;
`ifndef PE_ROW_SAT_EN
    logic [15:0] lo;
`endif
    s = ps[t];
    for (int k = 0; k < 4; k++)
      s += longint'(w_m[k]) * longint'(xs[t-k]);
`ifdef PE_ROW_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
`else
    lo = s[15:0];
    return int'($signed(lo));
`endif
  endfunction

  task automatic build_exp(input int n);
    exp_q.delete();
    for (int t = 3; t < n; t++) exp_q.push_back(model(t));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input int a, b, c, d);
    w_m = '{a, b, c, d};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_w_valid = 1'b1;
      i_w = 8'(w_m[k]);
    end
    @(negedge clk);
    i_w_valid = 1'b0;
  endtask

  // Drives one row of n beats and records every handoff.
  task automatic run_row(input int n, input int stall_n,
                         input bit rnd_rdy);
    int idx = 0;
    int cyc = 0;
    int post = 0;
    int stall_left = stall_n;
    bit seen = 0;
    got_q.delete();
    got_cyc.delete();
    done_n = 0; done_cyc = -1; last_acc = -1;
    stall_cnt = 0; stall_bad = 0;
    while (cyc < 500 && post < 3) begin
      @(negedge clk);
      if (o_valid) seen = 1;
      if (seen && stall_left > 0) begin
        i_ready = 1'b0;
        stall_left--;
      end else begin
        i_ready = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
      end
      i_valid = (idx < n);
      i_r     = (idx < n) ? 8'(xs[idx]) : 8'd0;
      i_psum  = (idx < n) ? 16'(ps[idx]) : 16'd0;
      i_last  = (idx == n - 1);
      #1;
      if (o_valid && !i_ready) begin
        stall_cnt++;
        if (got_q.size() >= exp_q.size()) stall_bad++;
        else if (int'($signed(o_psum)) != exp_q[got_q.size()]
                 || o_ready !== 1'b0) stall_bad++;
      end
      if (o_valid && i_ready) begin
        got_q.push_back(int'($signed(o_psum)));
        got_cyc.push_back(cyc);
      end
      if (i_valid && o_ready) begin
        idx++;
        last_acc = cyc;
      end
      if (o_done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (done_n > 0) post++;
      cyc++;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    i_w_valid = 0; i_w = 0; i_valid = 1; i_r = 0;
    i_psum = 0; i_last = 0; i_ready = 1;
    repeat (3) step();
    n_chk++; if (o_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", o_valid); else n_pass++;
    n_chk++; if (o_psum !== 16'd0) $display("FAIL rst_psum got=%0d exp=0", o_psum); else n_pass++;
    n_chk++; if (o_done !== 1'b0) $display("FAIL rst_done got=%b exp=0", o_done); else n_pass++;
    n_chk++; if (o_w_ready !== 1'b1) $display("FAIL rst_wready got=%b exp=1", o_w_ready); else n_pass++;
    n_chk++; if (o_ready !== 1'b0) $display("FAIL rst_ready_unloaded got=%b exp=0", o_ready); else n_pass++;
    rst = 1'b0; i_valid = 1'b0;
  endtask

  task automatic test_basic();
    load_w(1, 2, 3, 4);
    for (int i = 0; i < 5; i++) begin xs[i] = i + 1; ps[i] = 0; end
    build_exp(5);
    run_row(5, 0, 0);
    n_chk++; if (got_q.size() != 2) $display("FAIL basic_count got=%0d exp=2", got_q.size()); else n_pass++;
    n_chk++; if (got_q.size() < 1 || got_q[0] != 20) $display("FAIL basic_y0 got=%0d exp=20", got_q.size() > 0 ? got_q[0] : -1); else n_pass++;
    n_chk++; if (got_q.size() < 2 || got_q[1] != 30) $display("FAIL basic_y1 got=%0d exp=30", got_q.size() > 1 ? got_q[1] : -1); else n_pass++;
    n_chk++; if (got_cyc.size() < 2 || got_cyc[1] - got_cyc[0] != 1) $display("FAIL basic_b2b got=%0d exp=1", got_cyc.size() > 1 ? got_cyc[1] - got_cyc[0] : -1); else n_pass++;
    n_chk++; if (done_n != 1) $display("FAIL basic_done got=%0d exp=1", done_n); else n_pass++;
  endtask

  task automatic test_psum();
    for (int i = 0; i < 5; i++) begin xs[i] = i + 1; ps[i] = 100; end
    build_exp(5);
    run_row(5, 0, 0);
    n_chk++; if (got_q.size() != 2) $display("FAIL psum_count got=%0d exp=2", got_q.size()); else n_pass++;
    n_chk++; if (got_q.size() < 2 || got_q[0] != 120 || got_q[1] != 130) $display("FAIL psum_vals got=%0d,%0d exp=120,130", got_q.size() > 0 ? got_q[0] : -1, got_q.size() > 1 ? got_q[1] : -1); else n_pass++;
  endtask

  task automatic test_overflow();
    int e_pos, e_neg;
`ifdef PE_ROW_SAT_EN
    e_pos = 32767; e_neg = 32767;
`else
    e_pos = -1020; e_neg = 0;
`endif
    load_w(127, 127, 127, 127);
    for (int i = 0; i < 4; i++) begin xs[i] = 127; ps[i] = 0; end
    build_exp(4);
    run_row(4, 0, 0);
    n_chk++; if (got_q.size() != 1 || got_q[0] != e_pos) $display("FAIL ovf_pos got=%0d exp=%0d", got_q.size() > 0 ? got_q[0] : -1, e_pos); else n_pass++;
    load_w(-128, -128, -128, -128);
    for (int i = 0; i < 4; i++) xs[i] = -128;
    build_exp(4);
    run_row(4, 0, 0);
    n_chk++; if (got_q.size() != 1 || got_q[0] != e_neg) $display("FAIL ovf_neg got=%0d exp=%0d", got_q.size() > 0 ? got_q[0] : -1, e_neg); else n_pass++;
  endtask

  task automatic test_backpressure();
    load_w(1, 2, 3, 4);
    for (int i = 0; i < 5; i++) begin xs[i] = i + 1; ps[i] = 0; end
    build_exp(5);
    run_row(5, 3, 0);
    n_chk++; if (stall_cnt != 3) $display("FAIL bp_stalls got=%0d exp=3", stall_cnt); else n_pass++;
    n_chk++; if (stall_bad != 0) $display("FAIL bp_hold got=%0d bad stall cycles exp=0", stall_bad); else n_pass++;
    n_chk++; if (got_q.size() != 2 || got_q[0] != 20 || got_q[1] != 30) $display("FAIL bp_vals got=%0d results exp=20,30", got_q.size()); else n_pass++;
  endtask

  task automatic test_flush();
    xs[0] = 1; xs[1] = 2; ps[0] = 0; ps[1] = 0;
    run_row(2, 0, 0);
    n_chk++; if (got_q.size() != 0) $display("FAIL flush_noresult got=%0d exp=0", got_q.size()); else n_pass++;
    n_chk++; if (done_n != 1 || done_cyc - last_acc != 2) $display("FAIL flush_done got=%0d/%0d exp=1/2", done_n, done_cyc - last_acc); else n_pass++;
    for (int i = 0; i < 4; i++) begin xs[i] = i + 1; ps[i] = 0; end
    build_exp(4);
    run_row(4, 0, 0);
    n_chk++; if (got_q.size() != 1 || got_q[0] != 20) $display("FAIL norel_y got=%0d exp=20", got_q.size() > 0 ? got_q[0] : -1); else n_pass++;
  endtask

  task automatic test_enable();
    @(negedge clk);
    i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_valid = 1'b1; i_r = 8'(k); i_psum = 0; i_last = 1'b0;
      step();
    end
    i_valid = 1'b0;
    step();
    n_chk++; if (o_valid !== 1'b1 || o_psum !== 16'd20) $display("FAIL en_pre got=%b/%0d exp=1/20", o_valid, o_psum); else n_pass++;
    en = 1'b0; i_valid = 1'b1; i_r = 8'd5; i_last = 1'b1;
    repeat (2) begin
      step();
      n_chk++; if (o_valid !== 1'b1 || o_psum !== 16'd20 || o_done !== 1'b0) $display("FAIL en_frozen got=%b/%0d/%b exp=1/20/0", o_valid, o_psum, o_done); else n_pass++;
    end
    en = 1'b1;
    step();
    i_valid = 1'b0; i_last = 1'b0;
    n_chk++; if (o_valid !== 1'b0) $display("FAIL en_handoff got=%b exp=0", o_valid); else n_pass++;
    step();
    n_chk++; if (o_valid !== 1'b1 || o_psum !== 16'd30) $display("FAIL en_y1 got=%b/%0d exp=1/30", o_valid, o_psum); else n_pass++;
    step();
    n_chk++; if (o_done !== 1'b1 || o_valid !== 1'b0) $display("FAIL en_done got=%b/%b exp=1/0", o_done, o_valid); else n_pass++;
    step();
    n_chk++; if (o_done !== 1'b0) $display("FAIL en_pulse got=%b exp=0", o_done); else n_pass++;
  endtask

  task automatic test_reset_mid_row();
    i_valid = 1'b1; i_r = 8'd1; i_psum = 0; i_last = 0;
    step();
    i_r = 8'd2;
    step();
    step();
    rst = 1'b1; i_valid = 1'b0;
    step();
    rst = 1'b0;
    n_chk++; if (o_valid !== 1'b0 || o_psum !== 16'd0 || o_done !== 1'b0) $display("FAIL midrst_out got=%b/%0d/%b exp=0/0/0", o_valid, o_psum, o_done); else n_pass++;
    i_valid = 1'b1;
    #1;
    n_chk++; if (o_ready !== 1'b0) $display("FAIL midrst_unloaded got=%b exp=0", o_ready); else n_pass++;
    i_valid = 1'b0;
    load_w(1, 2, 3, 4);
    for (int i = 0; i < 4; i++) begin xs[i] = i + 1; ps[i] = 0; end
    build_exp(4);
    run_row(4, 0, 0);
    n_chk++; if (got_q.size() != 1 || got_q[0] != 20) $display("FAIL midrst_reload got=%0d exp=20", got_q.size() > 0 ? got_q[0] : -1); else n_pass++;
  endtask

  task automatic test_priority();
    @(negedge clk);
    w_m = '{2, 1, 1, 1};
    i_w_valid = 1'b1; i_w = 8'd2; i_valid = 1'b1; i_r = 8'd9;
    #1;
    n_chk++; if (o_ready !== 1'b0 || o_w_ready !== 1'b1) $display("FAIL prio got=%b/%b exp=0/1", o_ready, o_w_ready); else n_pass++;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      i_valid = 1'b0; i_w = 8'(w_m[k]);
    end
    @(negedge clk);
    i_w_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin xs[i] = i + 1; ps[i] = 0; end
    build_exp(4);
    run_row(4, 0, 0);
    n_chk++; if (got_q.size() != 1 || got_q[0] != 14 || got_q[0] != exp_q[0]) $display("FAIL prio_y got=%0d exp=14", got_q.size() > 0 ? got_q[0] : -1); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      if (it % 2 == 0)
        load_w(int'($urandom_range(255)) - 128,
               int'($urandom_range(255)) - 128,
               int'($urandom_range(255)) - 128,
               int'($urandom_range(255)) - 128);
      n = int'($urandom_range(12, 1));
      for (int i = 0; i < n; i++) begin
        xs[i] = int'($urandom_range(255)) - 128;
        ps[i] = int'($urandom_range(65535)) - 32768;
      end
      build_exp(n);
      run_row(n, 0, 1);
      n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL rnd_count it=%0d got=%0d exp=%0d", it, got_q.size(), exp_q.size()); else n_pass++;
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
        n_chk++; if (got_q[j] != exp_q[j]) $display("FAIL rnd_y it=%0d j=%0d got=%0d exp=%0d", it, j, got_q[j], exp_q[j]); else n_pass++;
      end
      n_chk++; if (done_n != 1) $display("FAIL rnd_done it=%0d got=%0d exp=1", it, done_n); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_psum();
    test_overflow();
    test_backpressure();
    test_flush();
    test_enable();
    test_reset_mid_row();
    test_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
